hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Pipeline hazard and stall sequencer for the 5-stage CPU. It detects load-use hazards, branch flushes and multi-cycle data-memory waits. It drives the PC/IF-ID write enables, the IF-ID flush and the bubble select of the ID-stage control mux (1 = zero WB/MEM/EX control). It also keeps saturating stall/flush performance counters and a memory-wait timeout watchdog.

Parameters:
TIMEOUT, 64, max consecutive MEM_WAIT cycles before entering ERROR (valid range 2..255)
CNT_W, 16, width of each performance counter

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous reset, active-low
IDEX_MemRead_i  input  1  instruction in EX is a load
IDEX_RegRt_i  input  5  load destination register in EX
IFID_RegRs_i  input  5  rs of instruction in ID
IFID_RegRt_i  input  5  rt of instruction in ID
branch_taken_i  input  1  branch in ID resolved taken
mem_req_i  input  1  MEM stage issues a data-memory access this cycle
mem_ready_i  input  1  data memory completes the access this cycle
pc_write_o  output  1  PC update enable
ifid_write_o  output  1  IF/ID register write enable
bubble_o  output  1  select of the ID control mux (1 = bubble)
ifid_flush_o  output  1  clear IF/ID to NOP
stall_all_o  output  1  freeze ID/EX, EX/MEM and MEM/WB
error_o  output  1  sticky memory-timeout flag
stall_cnt_o  output  CNT_W  cycles with pc_write_o=0, excluding reset and ERROR
flush_cnt_o  output  CNT_W  cycles with ifid_flush_o=1

Behaviour:
- State register values: RUN, MEM_WAIT, ERROR. The wait counter wcnt is 8 bits.
- Reset (rst_i=0 at a clock edge) sets state=RUN, wcnt=0, error_o=0 and both counters to 0.
- While rst_i=0, outputs are forced to pc_write_o=0, ifid_write_o=0, bubble_o=1, ifid_flush_o=0, stall_all_o=0. This override is combinational and takes effect in the same cycle.
- All other outputs are combinational from the current state and inputs, so there is zero latency to the pipeline.
- Signal definitions:
  - memwait = (RUN & mem_req_i & ~mem_ready_i) | (MEM_WAIT & ~mem_ready_i).
  - loaduse = IDEX_MemRead_i & (IDEX_RegRt_i != 0) & (IDEX_RegRt_i == IFID_RegRs_i | IDEX_RegRt_i == IFID_RegRt_i).
- Output priority, highest first:
  1. ERROR: pc_write_o=0, ifid_write_o=0, stall_all_o=1, bubble_o=1, ifid_flush_o=0.
  2. memwait: stall_all_o=1, pc_write_o=0, ifid_write_o=0, bubble_o=0 (freeze, not bubble), ifid_flush_o=0.
  3. loaduse: pc_write_o=0, ifid_write_o=0, bubble_o=1, stall_all_o=0. branch_taken_i is ignored because the branch is re-evaluated after the stall.
  4. branch_taken_i: ifid_flush_o=1, pc_write_o=1, ifid_write_o=1, bubble_o=0.
  5. Otherwise: pc_write_o=1, ifid_write_o=1, bubble_o=0, ifid_flush_o=0, stall_all_o=0.
- Transitions:
  - RUN -> MEM_WAIT when mem_req_i & ~mem_ready_i; wcnt<=1.
  - MEM_WAIT -> RUN when mem_ready_i; wcnt<=0. This is the release cycle: stall_all_o=0, and that cycle's outputs are evaluated by priorities 3-5.
  - MEM_WAIT & ~mem_ready_i: if wcnt==TIMEOUT, go to ERROR and set error_o<=1; otherwise wcnt<=wcnt+1.
  - ERROR is absorbing until reset.
- mem_req_i is ignored in MEM_WAIT (request held by the stalled MEM stage). mem_ready_i without a request in RUN is ignored.
- Counters:
  - stall_cnt_o increments when pc_write_o=0, rst_i=1 and state!=ERROR.
  - flush_cnt_o increments when ifid_flush_o=1.
  - Both saturate at 2^CNT_W-1 and do not wrap.

Test Plan:
- Load-use: IDEX_MemRead_i=1, IDEX_RegRt_i=5, IFID_RegRs_i=5 for 1 cycle -> that cycle bubble_o=1, pc_write_o=0, ifid_write_o=0; next cycle (MemRead=0) all normal; stall_cnt_o=1.
- Register-zero and no-match: RegRt=0 matching Rs=0, and RegRt=5 vs Rs=3/Rt=4 -> no stall, bubble_o=0.
- Branch vs load-use: branch_taken_i=1 alone -> ifid_flush_o=1, flush_cnt_o=1. Same with loaduse asserted -> flush=0, bubble_o=1.
- Memory wait: mem_req_i=1, mem_ready_i=0 for 3 cycles then 1 -> stall_all_o=1 for 3 cycles, bubble_o=0; release cycle stall_all_o=0; stall_cnt_o=3.
- Timeout: TIMEOUT=4, mem_ready_i held 0 -> error_o rises after 5 stalled cycles; outputs stay frozen; stall_cnt_o stops counting. rst_i=0 for 1 cycle -> RUN, error_o=0, counters 0.
- Saturation and reset mid-wait: CNT_W=2 with 5 stall cycles -> stall_cnt_o=3. rst_i=0 during MEM_WAIT -> same-cycle pc_write_o=0, bubble_o=1, stall_all_o=0; state RUN after the edge.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Hazard and stall sequencer for the 5-stage pipeline. It detects load-use
// hazards, taken-branch flushes and multi-cycle data-memory waits. It drives
// the front-end write enables, the IF/ID flush and the ID-stage bubble
// select. It also maintains saturating stall/flush counters and a
// memory-wait timeout watchdog with a sticky error flag.
//
// Parameters
//   TIMEOUT : consecutive MEM_WAIT cycles tolerated before ERROR (2..255)
//   CNT_W   : width of each performance counter
//
// Ports
//   clk_i, rst_i        : clock (rising edge), synchronous active-low reset
//   IDEX_MemRead_i      : instruction in EX is a load
//   IDEX_RegRt_i        : load destination register in EX
//   IFID_RegRs_i/RegRt_i: source registers of the instruction in ID
//   branch_taken_i      : branch in ID resolved taken
//   mem_req_i           : MEM stage issues a data-memory access
//   mem_ready_i         : data memory completes the access
//   pc_write_o          : PC update enable
//   ifid_write_o        : IF/ID write enable
//   bubble_o            : ID control mux select (1 = zero WB/MEM/EX control)
//   ifid_flush_o        : clear IF/ID to NOP
//   stall_all_o         : freeze ID/EX, EX/MEM and MEM/WB
//   error_o             : sticky memory-timeout flag
//   stall_cnt_o         : saturating count of stalled (pc_write_o=0) cycles
//   flush_cnt_o         : saturating count of flush cycles
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RegRt_i,
    input  logic [4:0]       IFID_RegRs_i,
    input  logic [4:0]       IFID_RegRt_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             bubble_o,
    output logic             ifid_flush_o,
    output logic             stall_all_o,
    output logic             error_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    localparam logic [7:0]       TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

    state_e           state_q, state_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic mem_wait_s;
    logic load_use_s;
    logic frozen_s;
    logic pc_write_s;
    logic ifid_write_s;
    logic bubble_s;
    logic ifid_flush_s;
    logic stall_all_s;

    // Any state other than RUN/MEM_WAIT (ERROR or an unreachable encoding)
    // holds the whole pipeline frozen.
    assign frozen_s = (state_q != ST_RUN) && (state_q != ST_MEM_WAIT);

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign load_use_s = IDEX_MemRead_i && (IDEX_RegRt_i != 5'd0) &&
                        ((IDEX_RegRt_i == IFID_RegRs_i) ||
                         (IDEX_RegRt_i == IFID_RegRt_i));

    // Memory wait: a fresh unanswered request in RUN, or an outstanding one.
    always_comb begin
        mem_wait_s = 1'b0;
        case (state_q)
            ST_RUN:      mem_wait_s = mem_req_i && !mem_ready_i;
            ST_MEM_WAIT: mem_wait_s = !mem_ready_i;
            default:     mem_wait_s = 1'b0;
        endcase
    end

    // Pipeline control outputs in priority order; reset overrides everything.
    always_comb begin
        pc_write_s   = 1'b1;
        ifid_write_s = 1'b1;
        bubble_s     = 1'b0;
        ifid_flush_s = 1'b0;
        stall_all_s  = 1'b0;
        if (!rst_i) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            bubble_s     = 1'b1;
        end else if (frozen_s) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            bubble_s     = 1'b1;
            stall_all_s  = 1'b1;
        end else if (mem_wait_s) begin
            // Freeze rather than bubble: the stalled instructions must survive.
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            stall_all_s  = 1'b1;
        end else if (load_use_s) begin
            // Branch is ignored here; it is re-evaluated after the stall.
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            bubble_s     = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_s = 1'b1;
        end else begin
            pc_write_s   = 1'b1;
            ifid_write_s = 1'b1;
        end
    end

    // Next state, wait counter and sticky timeout flag.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        error_d = error_q;
        case (state_q)
            ST_RUN: begin
                if (mem_req_i && !mem_ready_i) begin
                    state_d = ST_MEM_WAIT;
                    wcnt_d  = 8'd1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready_i) begin
                    state_d = ST_RUN;
                    wcnt_d  = 8'd0;
                end else if (wcnt_q == TIMEOUT_C) begin
                    state_d = ST_ERROR;
                    error_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                // Corrupted state register: fail safe into ERROR.
                state_d = ST_ERROR;
                error_d = 1'b1;
            end
        endcase
    end

    // Saturating performance counters; ERROR cycles are not counted as stalls.
    always_comb begin
        if (!pc_write_s && !frozen_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (ifid_flush_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ST_RUN;
            wcnt_q      <= 8'd0;
            error_q     <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            error_q     <= error_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_write_o   = pc_write_s;
    assign ifid_write_o = ifid_write_s;
    assign bubble_o     = bubble_s;
    assign ifid_flush_o = ifid_flush_s;
    assign stall_all_o  = stall_all_s;
    assign error_o      = error_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for hazard_stall_ctrl: constant vector table, hand-written
// multi-cycle sequences and a randomized run against a reference model.
// Two instances share the inputs: one with 16-bit counters, one with 2-bit
// counters to exercise saturation. Both use TIMEOUT=4.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int TMO = 4;

    logic       clk;
    logic       rst;
    logic       memrd;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       br;
    logic       req;
    logic       rdy;

    logic        pc_w, ifid_w, bub, fl, sa, err;
    logic [15:0] scnt, fcnt;
    logic        pc_w_s, ifid_w_s, bub_s, fl_s, sa_s, err_s;
    logic [1:0]  scnt_s, fcnt_s;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (abstract: flags plus a consecutive-wait length).
    bit     m_err, m_wait;
    int     m_wait_len;
    longint m_stall_n, m_flush_n;
    logic   e_pc, e_ifw, e_bub, e_fl, e_sa;

    hazard_stall_ctrl #(.TIMEOUT(TMO), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(memrd), .IDEX_RegRt_i(ex_rt),
        .IFID_RegRs_i(id_rs), .IFID_RegRt_i(id_rt), .branch_taken_i(br),
        .mem_req_i(req), .mem_ready_i(rdy), .pc_write_o(pc_w),
        .ifid_write_o(ifid_w), .bubble_o(bub), .ifid_flush_o(fl),
        .stall_all_o(sa), .error_o(err), .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
    );

    hazard_stall_ctrl #(.TIMEOUT(TMO), .CNT_W(2)) dut_s (
        .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(memrd), .IDEX_RegRt_i(ex_rt),
        .IFID_RegRs_i(id_rs), .IFID_RegRt_i(id_rt), .branch_taken_i(br),
        .mem_req_i(req), .mem_ready_i(rdy), .pc_write_o(pc_w_s),
        .ifid_write_o(ifid_w_s), .bubble_o(bub_s), .ifid_flush_o(fl_s),
        .stall_all_o(sa_s), .error_o(err_s), .stall_cnt_o(scnt_s), .flush_cnt_o(fcnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic       rst;
        logic       memrd;
        logic [4:0] ex_rt;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       br;
        logic       req;
        logic       rdy;
        logic       e_pc;
        logic       e_ifw;
        logic       e_bub;
        logic       e_fl;
        logic       e_sa;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, required %0d", nm, $time, act, expv);
        end
    endtask

    // Expected control outputs from the current inputs and model state.
    task automatic model_comb();
        bit waiting_now;
        bit hazard;
        waiting_now = m_wait ? !rdy : (req && !rdy);
        hazard = memrd && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
        {e_pc, e_ifw, e_bub, e_fl, e_sa} = 5'b11000;
        if (!rst)              {e_pc, e_ifw, e_bub, e_fl, e_sa} = 5'b00100;
        else if (m_err)        {e_pc, e_ifw, e_bub, e_fl, e_sa} = 5'b00101;
        else if (waiting_now)  {e_pc, e_ifw, e_bub, e_fl, e_sa} = 5'b00001;
        else if (hazard)       {e_pc, e_ifw, e_bub, e_fl, e_sa} = 5'b00100;
        else if (br)           {e_pc, e_ifw, e_bub, e_fl, e_sa} = 5'b11010;
    endtask

    // Drive one cycle of inputs and check the combinational outputs mid-cycle.
    task automatic apply(input logic r, input logic mr, input logic [4:0] xrt,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic b, input logic q, input logic y);
        rst = r; memrd = mr; ex_rt = xrt; id_rs = rs; id_rt = rt;
        br = b; req = q; rdy = y;
        #3;
        model_comb();
        chk("pc_write",   {31'd0, pc_w},   {31'd0, e_pc});
        chk("ifid_write", {31'd0, ifid_w}, {31'd0, e_ifw});
        chk("bubble",     {31'd0, bub},    {31'd0, e_bub});
        chk("ifid_flush", {31'd0, fl},     {31'd0, e_fl});
        chk("stall_all",  {31'd0, sa},     {31'd0, e_sa});
    endtask

    // Clock edge: advance the model and check the registered outputs.
    task automatic tick();
        longint lim16, lim2;
        model_comb();
        @(posedge clk);
        #1;
        if (!rst) begin
            m_err = 0; m_wait = 0; m_wait_len = 0; m_stall_n = 0; m_flush_n = 0;
        end else begin
            if (!m_err && !e_pc) m_stall_n++;
            if (e_fl) m_flush_n++;
            if (!m_err) begin
                if (m_wait ? !rdy : (req && !rdy)) begin
                    m_wait_len++;
                    if (m_wait_len > TMO) m_err = 1;
                    else m_wait = 1;
                end else begin
                    m_wait = 0;
                    m_wait_len = 0;
                end
            end
        end
        lim16 = 65535;
        lim2  = 3;
        chk("error",      {31'd0, err},   {31'd0, m_err});
        chk("error_s",    {31'd0, err_s}, {31'd0, m_err});
        chk("stall_cnt",  {16'd0, scnt},  32'((m_stall_n > lim16) ? lim16 : m_stall_n));
        chk("flush_cnt",  {16'd0, fcnt},  32'((m_flush_n > lim16) ? lim16 : m_flush_n));
        chk("stall_cnt2", {30'd0, scnt_s}, 32'((m_stall_n > lim2) ? lim2 : m_stall_n));
        chk("flush_cnt2", {30'd0, fcnt_s}, 32'((m_flush_n > lim2) ? lim2 : m_flush_n));
    endtask

    task automatic do_reset();
        apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic idle();
        apply(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        //                rst mr  xrt    rs     rt     br  req rdy   pc ifw bub fl sa
        vecs[0]  = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 5'd5, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state: forced outputs in the reset cycle, cleared registers after.
        do_reset();
        chk("rst_stall_cnt", {16'd0, scnt}, 32'd0);
        chk("rst_error",     {31'd0, err},  32'd0);

        // Vector table (vectors 10/11 enter and then release MEM_WAIT).
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].rst, vecs[i].memrd, vecs[i].ex_rt, vecs[i].id_rs,
                  vecs[i].id_rt, vecs[i].br, vecs[i].req, vecs[i].rdy);
            chk($sformatf("vec%0d_ctrl", i), {27'd0, pc_w, ifid_w, bub, fl, sa},
                {27'd0, vecs[i].e_pc, vecs[i].e_ifw, vecs[i].e_bub, vecs[i].e_fl, vecs[i].e_sa});
            tick();
        end

        // Load-use for one cycle, then normal operation; one stall counted.
        do_reset();
        apply(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        apply(1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("lu_next_pc", {31'd0, pc_w}, 32'd1);
        tick();
        chk("lu_stall_cnt", {16'd0, scnt}, 32'd1);

        // Branch alone flushes once; branch with load-use bubbles instead.
        do_reset();
        apply(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("br_flush_cnt", {16'd0, fcnt}, 32'd1);
        apply(1'b1, 1'b1, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        chk("br_lu_flush",  {31'd0, fl},  32'd0);
        chk("br_lu_bubble", {31'd0, bub}, 32'd1);
        tick();

        // Memory wait: three frozen cycles, then the release cycle.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            chk("mw_stall_all", {31'd0, sa},  32'd1);
            chk("mw_bubble",    {31'd0, bub}, 32'd0);
            tick();
        end
        apply(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("mw_release_sa", {31'd0, sa}, 32'd0);
        tick();
        chk("mw_stall_cnt", {16'd0, scnt}, 32'd3);

        // Timeout: error rises after TIMEOUT+1 stalled cycles, then freezes.
        do_reset();
        for (int i = 0; i < TMO + 1; i++) begin
            chk("to_err_early", {31'd0, err}, 32'd0);
            apply(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        chk("to_err", {31'd0, err}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
            chk("to_frozen", {27'd0, pc_w, ifid_w, bub, fl, sa}, {27'd0, 5'b00101});
            tick();
        end
        chk("to_stall_cnt", {16'd0, scnt}, 32'd5);
        do_reset();
        chk("to_rst_err",  {31'd0, err},  32'd0);
        chk("to_rst_scnt", {16'd0, scnt}, 32'd0);

        // Saturation: five load-use stalls leave the 2-bit counter at 3.
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("sat_cnt2",  {30'd0, scnt_s}, 32'd3);
        chk("sat_cnt16", {16'd0, scnt},   32'd5);

        // Reset during MEM_WAIT: same-cycle override, RUN afterwards.
        do_reset();
        apply(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("rmw_ctrl", {27'd0, pc_w, ifid_w, bub, fl, sa}, {27'd0, 5'b00100});
        tick();
        apply(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("rmw_run_sa", {31'd0, sa}, 32'd0);
        tick();

        // Randomized run against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 63) != 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0);
            tick();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
